// File: rtl/reg_file_2r1w.sv
// Two-read, one-write register file with write-first bypass, optional read output
// stage, reset values for the exported config registers and out-of-range detection.
module reg_file_2r1w #(
  parameter int                         WIDTH   = 8,
  parameter int                         DEPTH   = 16,
  parameter int                         ADDR_W  = 4,
  parameter int                         NUM_CFG = 4,
  parameter logic [NUM_CFG*WIDTH-1:0]   CFG_RST = 32'h2081_0000,
  parameter int                         RD_PIPE = 0
) (
  input  logic                       REF_CLK,
  input  logic                       RST,
  input  logic                       WrEN,
  input  logic [ADDR_W-1:0]          WrAddr,
  input  logic [WIDTH-1:0]           WrData,
  input  logic                       RdEN_A,
  input  logic [ADDR_W-1:0]          RdAddr_A,
  output logic [WIDTH-1:0]           RdData_A,
  output logic                       RdValid_A,
  input  logic                       RdEN_B,
  input  logic [ADDR_W-1:0]          RdAddr_B,
  output logic [WIDTH-1:0]           RdData_B,
  output logic                       RdValid_B,
  output logic                       AddrErr,
  output logic [NUM_CFG*WIDTH-1:0]   CFG_REGS
);

  localparam logic [ADDR_W:0]         DEPTH_L = (ADDR_W+1)'(DEPTH);
  // Reset image for the whole array: config slices at the bottom, zeros above.
  localparam logic [DEPTH*WIDTH-1:0]  RST_IMG = (DEPTH*WIDTH)'(CFG_RST);

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < DEPTH_L;
  endfunction

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wr_ok;
  logic [1:0]        rd_en;
  logic [ADDR_W-1:0] rd_addr [2];
  logic [WIDTH-1:0]  rd_word [2];
  logic [1:0]        rd_bad;
  logic [WIDTH-1:0]  s1_data [2];
  logic [1:0]        s1_valid;
  logic              err_q;

  assign wr_ok      = WrEN && in_range(WrAddr);
  assign rd_en      = {RdEN_B, RdEN_A};
  assign rd_addr[0] = RdAddr_A;
  assign rd_addr[1] = RdAddr_B;

  // NOTE: this array is reset like ordinary flops because the exported config
  // registers need defined power-up values; a plain RAM macro would not be reset.
  always_ff @(posedge REF_CLK) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RST_IMG[i*WIDTH +: WIDTH];
    end else if (wr_ok) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      mem[WrAddr] <= WrData;
    end
  end

  // NOTE: outputs get a default first so no path leaves them unassigned (no latch).
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_word[p] = '0;
      rd_bad[p]  = rd_en[p] && !in_range(rd_addr[p]);
      if (rd_en[p] && in_range(rd_addr[p])) begin
        rd_word[p] = (wr_ok && (WrAddr == rd_addr[p])) ? WrData : mem[rd_addr[p]];
      end
    end
  end

  // First read stage; data holds when the port is idle, valid drops.
  always_ff @(posedge REF_CLK) begin
    if (!RST) begin
      s1_valid <= '0;
      err_q    <= 1'b0;
      for (int p = 0; p < 2; p++) s1_data[p] <= '0;
    end else begin
      s1_valid <= rd_en;
      err_q    <= (WrEN && !in_range(WrAddr)) || (|rd_bad);
      for (int p = 0; p < 2; p++) begin
        if (rd_en[p]) s1_data[p] <= rd_word[p];
      end
    end
  end

  generate
    if (RD_PIPE != 0) begin : g_pipe
      logic [WIDTH-1:0] s2_data [2];
      logic [1:0]       s2_valid;

      always_ff @(posedge REF_CLK) begin
        if (!RST) begin
          s2_valid <= '0;
          for (int p = 0; p < 2; p++) s2_data[p] <= '0;
        end else begin
          s2_valid <= s1_valid;
          for (int p = 0; p < 2; p++) begin
            if (s1_valid[p]) s2_data[p] <= s1_data[p];
          end
        end
      end

      assign RdData_A  = s2_data[0];
      assign RdData_B  = s2_data[1];
      assign RdValid_A = s2_valid[0];
      assign RdValid_B = s2_valid[1];
    end else begin : g_direct
      assign RdData_A  = s1_data[0];
      assign RdData_B  = s1_data[1];
      assign RdValid_A = s1_valid[0];
      assign RdValid_B = s1_valid[1];
    end
  endgenerate

  // Address errors are flagged at the accepting edge regardless of read latency.
  assign AddrErr = err_q;

  generate
    for (genvar k = 0; k < NUM_CFG; k++) begin : g_cfg
      assign CFG_REGS[k*WIDTH +: WIDTH] = mem[k];
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench: two instances (16 regs/latency 1 and 12 regs/latency 2) share
// the same stimulus and are checked against an array model of the register file.
module tb_reg_file_2r1w;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        rd_en_a, rd_en_b;
  logic [3:0]  rd_addr_a, rd_addr_b;

  logic [7:0]  rd_data  [2][2];
  logic        rd_valid [2][2];
  logic        addr_err [2];
  logic [31:0] cfg      [2];

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  bit          mon_on   = 0;

  // Reference model state, one per instance.
  localparam int DEPTH_C [2] = '{16, 12};
  localparam int PIPE_C  [2] = '{0, 1};
  logic [7:0]  mem_m     [2][16];
  logic [7:0]  last_data [2][2];
  bit          err_exp   [2];
  exp_t        q         [2][2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reg_file_2r1w #(.DEPTH(16), .RD_PIPE(0)) dut0 (
    .REF_CLK(clk), .RST(rst_n), .WrEN(wr_en), .WrAddr(wr_addr), .WrData(wr_data),
    .RdEN_A(rd_en_a), .RdAddr_A(rd_addr_a), .RdData_A(rd_data[0][0]), .RdValid_A(rd_valid[0][0]),
    .RdEN_B(rd_en_b), .RdAddr_B(rd_addr_b), .RdData_B(rd_data[0][1]), .RdValid_B(rd_valid[0][1]),
    .AddrErr(addr_err[0]), .CFG_REGS(cfg[0])
  );

  reg_file_2r1w #(.DEPTH(12), .RD_PIPE(1)) dut1 (
    .REF_CLK(clk), .RST(rst_n), .WrEN(wr_en), .WrAddr(wr_addr), .WrData(wr_data),
    .RdEN_A(rd_en_a), .RdAddr_A(rd_addr_a), .RdData_A(rd_data[1][0]), .RdValid_A(rd_valid[1][0]),
    .RdEN_B(rd_en_b), .RdAddr_B(rd_addr_b), .RdData_B(rd_data[1][1]), .RdValid_B(rd_valid[1][1]),
    .AddrErr(addr_err[1]), .CFG_REGS(cfg[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic reset_model(input int d);
    logic [31:0] rst_img;
    rst_img = 32'h2081_0000;
    for (int i = 0; i < 16; i++) mem_m[d][i] = 8'h00;
    for (int k = 0; k < 4; k++) mem_m[d][k] = rst_img[k*8 +: 8];
    for (int p = 0; p < 2; p++) begin
      q[d][p].delete();
      last_data[d][p] = 8'h00;
    end
    err_exp[d] = 0;
  endtask

  // One clock of stimulus. Expectations are queued before the edge from the
  // pre-edge model; the model itself is updated right after the edge.
  task automatic step(input bit rst_v, input bit we, input int wa, input int wd,
                      input bit ea, input int aa, input bit eb, input int ab);
    bit   en  [2];
    int   ad  [2];
    bit   err [2];
    exp_t e;
    rst_n     = rst_v;
    wr_en     = we;
    wr_addr   = wa[3:0];
    wr_data   = wd[7:0];
    rd_en_a   = ea;
    rd_addr_a = aa[3:0];
    rd_en_b   = eb;
    rd_addr_b = ab[3:0];
    en = '{ea, eb};
    ad = '{aa, ab};
    for (int d = 0; d < 2; d++) begin
      err[d] = we && (wa >= DEPTH_C[d]);
      for (int p = 0; p < 2; p++) begin
        if (rst_v && en[p]) begin
          if (ad[p] >= DEPTH_C[d]) begin
            err[d] = 1;
            e.data = 8'h00;
          end else if (we && wa == ad[p]) begin
            e.data = wd[7:0];
          end else begin
            e.data = mem_m[d][ad[p]];
          end
          e.due = cyc + 1 + PIPE_C[d];
          q[d][p].push_back(e);
        end
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!rst_v) begin
        reset_model(d);
      end else begin
        if (we && wa < DEPTH_C[d]) mem_m[d][wa] = wd[7:0];
        err_exp[d] = err[d];
      end
    end
    @(negedge clk);
  endtask

  // Monitor: compares valid, data, hold value, AddrErr and CFG_REGS every cycle.
  always @(negedge clk) begin
    if (mon_on) begin
      for (int d = 0; d < 2; d++) begin
        logic [31:0] exp_cfg;
        for (int k = 0; k < 4; k++) exp_cfg[k*8 +: 8] = mem_m[d][k];
        check($sformatf("cfg_regs[d%0d]", d), cfg[d], exp_cfg);
        check($sformatf("addr_err[d%0d]", d), 32'(addr_err[d]), 32'(err_exp[d]));
        for (int p = 0; p < 2; p++) begin
          bit exp_v;
          while (q[d][p].size() > 0 && q[d][p][0].due < cyc) void'(q[d][p].pop_front());
          exp_v = (q[d][p].size() > 0) && (q[d][p][0].due == cyc);
          check($sformatf("rd_valid[d%0d p%0d] cyc %0d", d, p, cyc),
                32'(rd_valid[d][p]), 32'(exp_v));
          if (exp_v) begin
            exp_t e;
            e = q[d][p].pop_front();
            last_data[d][p] = e.data;
          end
          check($sformatf("rd_data[d%0d p%0d] cyc %0d", d, p, cyc),
                32'(rd_data[d][p]), 32'(last_data[d][p]));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en_a = 1'b0; rd_addr_a = '0; rd_en_b = 1'b0; rd_addr_b = '0;
    mon_on = 1;
    // Reset, then default reads of the config and plain registers.
    step(0, 0, 0, 0, 1, 2, 1, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 2, 1, 3);
    step(1, 0, 0, 0, 1, 9, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // Write then dual read.
    step(1, 1, 7, 8'h5A, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 7, 1, 3);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // Write-first bypass on both ports, then a later read.
    step(1, 1, 5, 8'hC3, 1, 5, 1, 5);
    step(1, 0, 0, 0, 1, 5, 0, 0);
    // Back-to-back reads of the config registers.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, i, 1, 3 - i);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // Out-of-range on the 12-register instance.
    step(1, 1, 13, 8'hFF, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 14, 1, 13);
    step(1, 1, 2, 8'h11, 1, 15, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // Reset right behind an in-flight read.
    step(1, 0, 0, 0, 1, 2, 1, 7);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // Randomized traffic with frequent same-address bypass and rare resets.
    for (int n = 0; n < 600; n++) begin
      int wa, aa, ab;
      wa = $urandom_range(0, 15);
      aa = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 15);
      ab = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 15);
      step($urandom_range(0, 63) != 0, $urandom_range(0, 1) == 1, wa, $urandom_range(0, 255),
           $urandom_range(0, 2) != 0, aa, $urandom_range(0, 2) != 0, ab);
    end
    for (int n = 0; n < 4; n++) step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++)
        check($sformatf("drain[d%0d p%0d]", d, p), q[d][p].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
